// File: rtl/tlb_op_ctrl.sv
// TLB maintenance-operation sequencer: accepts SRCH/RD/WR/FILL/INV requests,
// drives the matching MMU port for one cycle and returns CSR write-back data.
module tlb_op_ctrl (
  input  logic        Clk,
  input  logic        Rest,
  input  logic        OpValid,
  output logic        OpReady,
  input  logic [2:0]  OpCode,
  input  logic [4:0]  OpInvOp,
  input  logic [9:0]  OpInvAsid,
  input  logic [18:0] OpInvVppn,
  input  logic [31:0] CsrTlbIdx,
  input  logic [31:0] CsrTlbEhi,
  input  logic [31:0] CsrTlbElo0,
  input  logic [31:0] CsrTlbElo1,
  input  logic [9:0]  CsrAsid,
  output logic        CsrSerchTlbAble,
  output logic [63:0] CsrSerchInfrom,
  input  logic [5:0]  CsrSerchIdxDate,
  input  logic        MmuSerchHit,
  output logic [5:0]  CsrReadTlbAddr,
  input  logic [88:0] CsrReadTlbDate,
  output logic        CsrWriteTlbAble,
  output logic [5:0]  CsrWriteTlbAddr,
  output logic [88:0] CsrWriteTlbDate,
  output logic        CsrInvEn,
  output logic [4:0]  CsrInvOp,
  output logic [9:0]  CsrInvAsid,
  output logic [18:0] CsrInvVppn,
  input  logic        MmuStop,
  input  logic        MmuFlash,
  output logic        RspValid,
  output logic        RspErr,
  output logic [3:0]  RspWeMask,
  output logic [31:0] RspTlbIdx,
  output logic [31:0] RspTlbEhi,
  output logic [31:0] RspTlbElo0,
  output logic [31:0] RspTlbElo1,
  output logic [9:0]  RspAsid
);

  localparam int unsigned IDX_W   = 6;
  localparam int unsigned ENTRY_W = 89;
  localparam int unsigned HALF_W  = 26;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [4:0]         inv_op_q, inv_op_d;
  logic [9:0]         inv_asid_q, inv_asid_d;
  logic [18:0]        inv_vppn_q, inv_vppn_d;
  logic [31:0]        idx_q, idx_d, ehi_q, ehi_d, elo0_q, elo0_d, elo1_q, elo1_d;
  logic [9:0]         asid_q, asid_d;
  logic [IDX_W-1:0]   fill_addr_q, fill_addr_d, cnt_q, cnt_d;

  logic               op_ready_q, op_ready_d;
  logic               serch_able_q, serch_able_d;
  logic [63:0]        serch_info_q, serch_info_d;
  logic [IDX_W-1:0]   read_addr_q, read_addr_d;
  logic               write_able_q, write_able_d;
  logic [IDX_W-1:0]   write_addr_q, write_addr_d;
  logic [ENTRY_W-1:0] write_data_q, write_data_d;
  logic               inv_en_q, inv_en_d;
  logic [4:0]         csr_inv_op_q, csr_inv_op_d;
  logic [9:0]         csr_inv_asid_q, csr_inv_asid_d;
  logic [18:0]        csr_inv_vppn_q, csr_inv_vppn_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [3:0]         rsp_mask_q, rsp_mask_d;
  logic [31:0]        rsp_idx_q, rsp_idx_d, rsp_ehi_q, rsp_ehi_d;
  logic [31:0]        rsp_elo0_q, rsp_elo0_d, rsp_elo1_q, rsp_elo1_d;
  logic [9:0]         rsp_asid_q, rsp_asid_d;

  logic               op_illegal;
  logic [ENTRY_W-1:0] wr_entry;
  logic [18:0]        rd_vppn;
  logic [9:0]         rd_asid;
  logic               rd_g, rd_e;
  logic [5:0]         rd_ps;
  logic [HALF_W-1:0]  rd_half0, rd_half1;

  // Entry half {V,D,MAT,PLV,PPN} to the TLBELO CSR layout.
  function automatic logic [31:0] elo_from_half(input logic [HALF_W-1:0] h, input logic g);
    return {4'd0, h[19:0], 1'b0, g, h[23:22], h[21:20], h[24], h[25]};
  endfunction

  assign op_illegal = (op_q > OP_INV) || ((op_q == OP_INV) && (inv_op_q > 5'd6));

  assign wr_entry = {ehi_q[31:13], asid_q, elo0_q[6] & elo1_q[6], idx_q[29:24], ~idx_q[31],
                     elo0_q[0], elo0_q[1], elo0_q[5:4], elo0_q[3:2], elo0_q[27:8],
                     elo1_q[0], elo1_q[1], elo1_q[5:4], elo1_q[3:2], elo1_q[27:8]};

  assign rd_vppn  = CsrReadTlbDate[88:70];
  assign rd_asid  = CsrReadTlbDate[69:60];
  assign rd_g     = CsrReadTlbDate[59];
  assign rd_ps    = CsrReadTlbDate[58:53];
  assign rd_e     = CsrReadTlbDate[52];
  assign rd_half0 = CsrReadTlbDate[51:26];
  assign rd_half1 = CsrReadTlbDate[25:0];

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      inv_op_q       <= '0;
      inv_asid_q     <= '0;
      inv_vppn_q     <= '0;
      idx_q          <= '0;
      ehi_q          <= '0;
      elo0_q         <= '0;
      elo1_q         <= '0;
      asid_q         <= '0;
      fill_addr_q    <= '0;
      cnt_q          <= '0;
      op_ready_q     <= 1'b1;
      serch_able_q   <= 1'b0;
      serch_info_q   <= '0;
      read_addr_q    <= '0;
      write_able_q   <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      inv_en_q       <= 1'b0;
      csr_inv_op_q   <= '0;
      csr_inv_asid_q <= '0;
      csr_inv_vppn_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_mask_q     <= '0;
      rsp_idx_q      <= '0;
      rsp_ehi_q      <= '0;
      rsp_elo0_q     <= '0;
      rsp_elo1_q     <= '0;
      rsp_asid_q     <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      inv_op_q       <= inv_op_d;
      inv_asid_q     <= inv_asid_d;
      inv_vppn_q     <= inv_vppn_d;
      idx_q          <= idx_d;
      ehi_q          <= ehi_d;
      elo0_q         <= elo0_d;
      elo1_q         <= elo1_d;
      asid_q         <= asid_d;
      fill_addr_q    <= fill_addr_d;
      cnt_q          <= cnt_d;
      op_ready_q     <= op_ready_d;
      serch_able_q   <= serch_able_d;
      serch_info_q   <= serch_info_d;
      read_addr_q    <= read_addr_d;
      write_able_q   <= write_able_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      inv_en_q       <= inv_en_d;
      csr_inv_op_q   <= csr_inv_op_d;
      csr_inv_asid_q <= csr_inv_asid_d;
      csr_inv_vppn_q <= csr_inv_vppn_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_mask_q     <= rsp_mask_d;
      rsp_idx_q      <= rsp_idx_d;
      rsp_ehi_q      <= rsp_ehi_d;
      rsp_elo0_q     <= rsp_elo0_d;
      rsp_elo1_q     <= rsp_elo1_d;
      rsp_asid_q     <= rsp_asid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    inv_op_d       = inv_op_q;
    inv_asid_d     = inv_asid_q;
    inv_vppn_d     = inv_vppn_q;
    idx_d          = idx_q;
    ehi_d          = ehi_q;
    elo0_d         = elo0_q;
    elo1_d         = elo1_q;
    asid_d         = asid_q;
    fill_addr_d    = fill_addr_q;
    cnt_d          = cnt_q + 6'd1;
    serch_able_d   = 1'b0;
    serch_info_d   = serch_info_q;
    read_addr_d    = read_addr_q;
    write_able_d   = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    inv_en_d       = 1'b0;
    csr_inv_op_d   = csr_inv_op_q;
    csr_inv_asid_d = csr_inv_asid_q;
    csr_inv_vppn_d = csr_inv_vppn_q;
    rsp_valid_d    = 1'b0;
    rsp_err_d      = rsp_err_q;
    rsp_mask_d     = rsp_mask_q;
    rsp_idx_d      = rsp_idx_q;
    rsp_ehi_d      = rsp_ehi_q;
    rsp_elo0_d     = rsp_elo0_q;
    rsp_elo1_d     = rsp_elo1_q;
    rsp_asid_d     = rsp_asid_q;

    case (state_q)
      S_IDLE: begin
        // A flush in IDLE blocks acceptance so the block stays parked.
        if (OpValid && !MmuFlash) begin
          op_d        = OpCode;
          inv_op_d    = OpInvOp;
          inv_asid_d  = OpInvAsid;
          inv_vppn_d  = OpInvVppn;
          idx_d       = CsrTlbIdx;
          ehi_d       = CsrTlbEhi;
          elo0_d      = CsrTlbElo0;
          elo1_d      = CsrTlbElo1;
          asid_d      = CsrAsid;
          fill_addr_d = cnt_q;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (MmuFlash) begin
          state_d = S_IDLE;
        end else if (!MmuStop) begin
          state_d = S_WAIT;
          case (op_q)
            OP_SRCH: begin
              serch_able_d = 1'b1;
              serch_info_d = {ehi_q[31:13], asid_q, 35'd0};
            end
            OP_RD: read_addr_d = idx_q[IDX_W-1:0];
            OP_WR: begin
              write_able_d = 1'b1;
              write_addr_d = idx_q[IDX_W-1:0];
              write_data_d = wr_entry;
            end
            OP_FILL: begin
              write_able_d = 1'b1;
              write_addr_d = fill_addr_q;
              write_data_d = wr_entry;
            end
            OP_INV: begin
              if (!op_illegal) begin
                inv_en_d       = 1'b1;
                csr_inv_op_d   = inv_op_q;
                csr_inv_asid_d = inv_asid_q;
                csr_inv_vppn_d = inv_vppn_q;
              end
            end
            default: ;
          endcase
        end
      end
      S_WAIT: begin
        if (MmuFlash) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = op_illegal;
          rsp_mask_d  = 4'b0000;
          rsp_idx_d   = idx_q;
          rsp_ehi_d   = ehi_q;
          rsp_elo0_d  = elo0_q;
          rsp_elo1_d  = elo1_q;
          rsp_asid_d  = asid_q;
          if (op_q == OP_SRCH) begin
            rsp_mask_d = 4'b1000;
            rsp_idx_d  = MmuSerchHit ? {1'b0, idx_q[30:6], CsrSerchIdxDate}
                                     : {1'b1, idx_q[30:0]};
          end else if (op_q == OP_RD) begin
            // An empty entry clears everything except the kept TLBIDX bits.
            rsp_mask_d = 4'b1111;
            if (rd_e) begin
              rsp_idx_d  = {1'b0, idx_q[30], rd_ps, idx_q[23:0]};
              rsp_ehi_d  = {rd_vppn, 13'd0};
              rsp_elo0_d = elo_from_half(rd_half0, rd_g);
              rsp_elo1_d = elo_from_half(rd_half1, rd_g);
              rsp_asid_d = rd_asid;
            end else begin
              rsp_idx_d  = {1'b1, idx_q[30], 6'd0, idx_q[23:0]};
              rsp_ehi_d  = '0;
              rsp_elo0_d = '0;
              rsp_elo1_d = '0;
              rsp_asid_d = '0;
            end
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    op_ready_d = (state_d == S_IDLE);
  end

  assign OpReady         = op_ready_q;
  assign CsrSerchTlbAble = serch_able_q;
  assign CsrSerchInfrom  = serch_info_q;
  assign CsrReadTlbAddr  = read_addr_q;
  assign CsrWriteTlbAble = write_able_q;
  assign CsrWriteTlbAddr = write_addr_q;
  assign CsrWriteTlbDate = write_data_q;
  assign CsrInvEn        = inv_en_q;
  assign CsrInvOp        = csr_inv_op_q;
  assign CsrInvAsid      = csr_inv_asid_q;
  assign CsrInvVppn      = csr_inv_vppn_q;
  assign RspValid        = rsp_valid_q;
  assign RspErr          = rsp_err_q;
  assign RspWeMask       = rsp_mask_q;
  assign RspTlbIdx       = rsp_idx_q;
  assign RspTlbEhi       = rsp_ehi_q;
  assign RspTlbElo0      = rsp_elo0_q;
  assign RspTlbElo1      = rsp_elo1_q;
  assign RspAsid         = rsp_asid_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Randomized bench for tlb_op_ctrl against a field-level reference model of
// the TLB operations, plus directed corner scenarios.
module tb_tlb_op_ctrl;

  logic        Clk = 1'b0;
  logic        Rest, OpValid, MmuSerchHit, MmuStop, MmuFlash;
  logic [2:0]  OpCode;
  logic [4:0]  OpInvOp;
  logic [9:0]  OpInvAsid, CsrAsid;
  logic [18:0] OpInvVppn;
  logic [31:0] CsrTlbIdx, CsrTlbEhi, CsrTlbElo0, CsrTlbElo1;
  logic [5:0]  CsrSerchIdxDate;
  logic [88:0] CsrReadTlbDate;
  logic        OpReady, CsrSerchTlbAble, CsrWriteTlbAble, CsrInvEn, RspValid, RspErr;
  logic [63:0] CsrSerchInfrom;
  logic [5:0]  CsrReadTlbAddr, CsrWriteTlbAddr;
  logic [88:0] CsrWriteTlbDate;
  logic [4:0]  CsrInvOp;
  logic [9:0]  CsrInvAsid, RspAsid;
  logic [18:0] CsrInvVppn;
  logic [3:0]  RspWeMask;
  logic [31:0] RspTlbIdx, RspTlbEhi, RspTlbElo0, RspTlbElo1;

  int n_total = 0;
  int n_bad   = 0;
  int n_edges = 0;

  int          g_strobes, g_strobe_cyc, g_rsp_cnt, g_rsp_cyc;
  logic [63:0] g_infrom;
  logic [5:0]  g_waddr;
  logic [88:0] g_wdata;
  logic [31:0] g_rsp_idx, g_rsp_ehi;
  logic [3:0]  g_rsp_mask;
  logic        g_rsp_err;

  tlb_op_ctrl dut (
    .Clk(Clk), .Rest(Rest), .OpValid(OpValid), .OpReady(OpReady), .OpCode(OpCode),
    .OpInvOp(OpInvOp), .OpInvAsid(OpInvAsid), .OpInvVppn(OpInvVppn),
    .CsrTlbIdx(CsrTlbIdx), .CsrTlbEhi(CsrTlbEhi), .CsrTlbElo0(CsrTlbElo0),
    .CsrTlbElo1(CsrTlbElo1), .CsrAsid(CsrAsid),
    .CsrSerchTlbAble(CsrSerchTlbAble), .CsrSerchInfrom(CsrSerchInfrom),
    .CsrSerchIdxDate(CsrSerchIdxDate), .MmuSerchHit(MmuSerchHit),
    .CsrReadTlbAddr(CsrReadTlbAddr), .CsrReadTlbDate(CsrReadTlbDate),
    .CsrWriteTlbAble(CsrWriteTlbAble), .CsrWriteTlbAddr(CsrWriteTlbAddr),
    .CsrWriteTlbDate(CsrWriteTlbDate), .CsrInvEn(CsrInvEn), .CsrInvOp(CsrInvOp),
    .CsrInvAsid(CsrInvAsid), .CsrInvVppn(CsrInvVppn), .MmuStop(MmuStop),
    .MmuFlash(MmuFlash), .RspValid(RspValid), .RspErr(RspErr), .RspWeMask(RspWeMask),
    .RspTlbIdx(RspTlbIdx), .RspTlbEhi(RspTlbEhi), .RspTlbElo0(RspTlbElo0),
    .RspTlbElo1(RspTlbElo1), .RspAsid(RspAsid)
  );

  always #5 Clk = ~Clk;

  // Clock edges seen since reset release: the expected FILL slot.
  always @(posedge Clk or posedge Rest) begin
    if (Rest) n_edges <= 0;
    else      n_edges <= n_edges + 1;
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int unsigned fld(input logic [88:0] v, input int lsb, input int w);
    logic [88:0] s;
    s = v >> lsb;
    return 32'(s) & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] m_elo(input int unsigned h, input int unsigned g);
    int unsigned v, d, mat, plv, ppn;
    v = (h >> 25) & 1; d = (h >> 24) & 1; mat = (h >> 22) & 3;
    plv = (h >> 20) & 3; ppn = h & 32'hFFFFF;
    return ppn * 256 + g * 64 + mat * 16 + plv * 4 + d * 2 + v;
  endfunction

  function automatic int unsigned m_half(input int unsigned elo);
    return (elo & 1) * (1 << 25) + ((elo >> 1) & 1) * (1 << 24) + ((elo >> 4) & 3) * (1 << 22)
         + ((elo >> 2) & 3) * (1 << 20) + ((elo >> 8) & 32'hFFFFF);
  endfunction

  function automatic logic [88:0] m_wdata(input logic [31:0] idx, ehi, elo0, elo1, input logic [9:0] asid);
    int unsigned g, ps, e;
    g  = (elo0 >> 6) & (elo1 >> 6) & 1;
    ps = (idx >> 24) & 63;
    e  = idx[31] ? 0 : 1;
    return (89'(ehi >> 13) << 70) | (89'(asid) << 60) | (89'(g) << 59) | (89'(ps) << 53)
         | (89'(e) << 52) | (89'(m_half(elo0)) << 26) | 89'(m_half(elo1));
  endfunction

  function automatic logic [63:0] m_info(input logic [31:0] ehi, input logic [9:0] asid);
    return (64'(ehi >> 13) << 45) | (64'(asid) << 35);
  endfunction

  task automatic m_rsp(input logic [2:0] op, input logic [4:0] invop,
                       input logic [31:0] idx, ehi, elo0, elo1, input logic [9:0] asid,
                       input logic [5:0] sidx, input logic hit, input logic [88:0] ent,
                       output logic err, output logic [3:0] mask,
                       output logic [31:0] ridx, rehi, relo0, relo1, output logic [9:0] rasid);
    int unsigned g;
    err = (op > 3'd4) || (op == 3'd4 && invop > 5'd6);
    mask = 4'h0; ridx = idx; rehi = ehi; relo0 = elo0; relo1 = elo1; rasid = asid;
    if (op == 3'd0) begin
      mask = 4'h8;
      ridx = hit ? ((idx & 32'h7FFF_FFC0) | 32'(sidx)) : (idx | 32'h8000_0000);
    end else if (op == 3'd1) begin
      mask = 4'hF;
      if (fld(ent, 52, 1) == 1) begin
        g     = fld(ent, 59, 1);
        ridx  = (idx & 32'h40FF_FFFF) | (fld(ent, 53, 6) << 24);
        rehi  = fld(ent, 70, 19) << 13;
        rasid = 10'(fld(ent, 60, 10));
        relo0 = m_elo(fld(ent, 26, 26), g);
        relo1 = m_elo(fld(ent, 0, 26), g);
      end else begin
        ridx = (idx & 32'h40FF_FFFF) | 32'h8000_0000;
        rehi = '0; relo0 = '0; relo1 = '0; rasid = '0;
      end
    end
  endtask

  task automatic rand_csr();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    CsrTlbIdx = $urandom(); CsrTlbEhi = $urandom();
    CsrTlbElo0 = $urandom(); CsrTlbElo1 = $urandom();
    CsrAsid = 10'($urandom()); OpInvAsid = 10'($urandom()); OpInvVppn = 19'($urandom());
    CsrSerchIdxDate = 6'($urandom()); MmuSerchHit = 1'($urandom());
    CsrReadTlbDate = t[88:0];
  endtask

  // One request with MmuStop held k_stop cycles and optional flush at cycle flash_cyc.
  task automatic run_op(input logic [2:0] op, input logic [4:0] invop, input int k_stop, input int flash_cyc);
    logic [31:0] s_idx, s_ehi, s_elo0, s_elo1, e_idx, e_ehi, e_elo0, e_elo1;
    logic [9:0]  s_asid, s_iasid, e_asid;
    logic [18:0] s_ivppn;
    logic        e_err;
    logic [3:0]  e_mask;
    logic [2:0]  kind, e_kind;
    int          fill_exp, exp_strobes, exp_rsp, ready_cyc, n;
    bit          issued;
    @(negedge Clk);
    chk("ready_idle", 128'(OpReady), 128'(1));
    OpValid = 1'b1; OpCode = op; OpInvOp = invop;
    fill_exp = n_edges % 64;
    s_idx = CsrTlbIdx; s_ehi = CsrTlbEhi; s_elo0 = CsrTlbElo0; s_elo1 = CsrTlbElo1;
    s_asid = CsrAsid; s_iasid = OpInvAsid; s_ivppn = OpInvVppn;
    m_rsp(op, invop, s_idx, s_ehi, s_elo0, s_elo1, s_asid, CsrSerchIdxDate, MmuSerchHit,
          CsrReadTlbDate, e_err, e_mask, e_idx, e_ehi, e_elo0, e_elo1, e_asid);
    e_kind = (op == 3'd0) ? 3'b100 : (op == 3'd2 || op == 3'd3) ? 3'b010
           : (op == 3'd4 && invop <= 5'd6) ? 3'b001 : 3'b000;
    issued = (flash_cyc == 0) || (flash_cyc > k_stop + 1);
    exp_strobes = (e_kind != 3'b000 && issued) ? 1 : 0;
    exp_rsp = (flash_cyc == 0) ? 1 : 0;
    ready_cyc = (flash_cyc == 0) ? k_stop + 4 : flash_cyc + 1;
    g_strobes = 0; g_strobe_cyc = 0; g_rsp_cnt = 0; g_rsp_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      kind = {CsrSerchTlbAble, CsrWriteTlbAble, CsrInvEn};
      n = int'(CsrSerchTlbAble) + int'(CsrWriteTlbAble) + int'(CsrInvEn);
      if (n > 0) begin
        g_strobes += n; g_strobe_cyc = c;
        g_infrom = CsrSerchInfrom; g_waddr = CsrWriteTlbAddr; g_wdata = CsrWriteTlbDate;
        chk("strobe_kind", 128'(kind), 128'(e_kind));
        if (op == 3'd0) chk("serch_info", 128'(CsrSerchInfrom), 128'(m_info(s_ehi, s_asid)));
        if (op == 3'd2 || op == 3'd3) begin
          chk("wr_addr", 128'(CsrWriteTlbAddr), (op == 3'd2) ? 128'(s_idx[5:0]) : 128'(fill_exp));
          chk("wr_data", 128'(CsrWriteTlbDate), 128'(m_wdata(s_idx, s_ehi, s_elo0, s_elo1, s_asid)));
        end
        if (op == 3'd4) begin
          chk("inv_op", 128'(CsrInvOp), 128'(invop));
          chk("inv_asid", 128'(CsrInvAsid), 128'(s_iasid));
          chk("inv_vppn", 128'(CsrInvVppn), 128'(s_ivppn));
        end
      end
      if (op == 3'd1 && issued && c == k_stop + 2)
        chk("rd_addr", 128'(CsrReadTlbAddr), 128'(s_idx[5:0]));
      if (RspValid) begin
        g_rsp_cnt++; g_rsp_cyc = c;
        g_rsp_idx = RspTlbIdx; g_rsp_ehi = RspTlbEhi; g_rsp_mask = RspWeMask; g_rsp_err = RspErr;
        chk("rsp_err", 128'(RspErr), 128'(e_err));
        chk("rsp_mask", 128'(RspWeMask), 128'(e_mask));
        chk("rsp_idx", 128'(RspTlbIdx), 128'(e_idx));
        chk("rsp_ehi", 128'(RspTlbEhi), 128'(e_ehi));
        chk("rsp_elo0", 128'(RspTlbElo0), 128'(e_elo0));
        chk("rsp_elo1", 128'(RspTlbElo1), 128'(e_elo1));
        chk("rsp_asid", 128'(RspAsid), 128'(e_asid));
      end
      if (c == ready_cyc - 1) chk("ready_busy", 128'(OpReady), 128'(0));
      if (c == ready_cyc)     chk("ready_back", 128'(OpReady), 128'(1));
      if (c == 1) begin
        OpValid = 1'b0;
        OpCode = 3'($urandom()); OpInvOp = 5'($urandom());
        CsrTlbIdx = $urandom(); CsrTlbEhi = $urandom(); CsrTlbElo0 = $urandom();
        CsrTlbElo1 = $urandom(); CsrAsid = 10'($urandom());
        OpInvAsid = 10'($urandom()); OpInvVppn = 19'($urandom());
      end
      MmuStop  = (c <= k_stop);
      MmuFlash = (c == flash_cyc);
    end
    chk("strobe_cnt", 128'(g_strobes), 128'(exp_strobes));
    if (exp_strobes > 0) chk("strobe_cyc", 128'(g_strobe_cyc), 128'(k_stop + 2));
    chk("rsp_cnt", 128'(g_rsp_cnt), 128'(exp_rsp));
    if (exp_rsp > 0) chk("rsp_cyc", 128'(g_rsp_cyc), 128'(k_stop + 3));
  endtask

  initial begin
    int k, f, s, r;
    logic [88:0] ent;
    Rest = 1'b1; OpValid = 1'b0; OpCode = '0; OpInvOp = '0; MmuStop = 1'b0; MmuFlash = 1'b0;
    rand_csr();
    repeat (3) @(negedge Clk);
    chk("rst_rspvalid", 128'(RspValid), 128'(0));
    chk("rst_rsperr", 128'(RspErr), 128'(0));
    chk("rst_wr_able", 128'(CsrWriteTlbAble), 128'(0));
    chk("rst_infrom", 128'(CsrSerchInfrom), 128'(0));
    chk("rst_wdata", 128'(CsrWriteTlbDate), 128'(0));
    chk("rst_rspidx", 128'(RspTlbIdx), 128'(0));
    Rest = 1'b0;
    @(negedge Clk);
    chk("rst_ready", 128'(OpReady), 128'(1));

    rand_csr(); CsrTlbEhi = 32'h1234_6000; MmuSerchHit = 1'b1; CsrSerchIdxDate = 6'd5;
    run_op(3'd0, 5'd0, 0, 0);
    chk("srch_vppn", 128'(g_infrom[63:45]), 128'(19'h091A3));
    chk("srch_ne", 128'(g_rsp_idx[31]), 128'(0));
    chk("srch_index", 128'(g_rsp_idx[5:0]), 128'(5));
    chk("srch_cycle", 128'(g_rsp_cyc), 128'(3));

    rand_csr(); CsrTlbIdx = 32'h0000_0007; ent = CsrReadTlbDate; ent[52] = 1'b0; CsrReadTlbDate = ent;
    run_op(3'd1, 5'd0, 0, 0);
    chk("rd_ne", 128'(g_rsp_idx[31]), 128'(1));
    chk("rd_ps", 128'(g_rsp_idx[29:24]), 128'(0));
    chk("rd_ehi", 128'(g_rsp_ehi), 128'(0));
    chk("rd_mask", 128'(g_rsp_mask), 128'(4'hF));

    rand_csr(); CsrTlbIdx = 32'h0C00_000A;
    run_op(3'd2, 5'd0, 0, 0);
    chk("wr_addr10", 128'(g_waddr), 128'(10));
    chk("wr_ps12", 128'(g_wdata[58:53]), 128'(12));
    chk("wr_e1", 128'(g_wdata[52]), 128'(1));
    chk("wr_pulses", 128'(g_strobes), 128'(1));

    rand_csr(); run_op(3'd4, 5'd7, 0, 0);
    chk("inv7_pulses", 128'(g_strobes), 128'(0));
    chk("inv7_err", 128'(g_rsp_err), 128'(1));
    chk("inv7_rsps", 128'(g_rsp_cnt), 128'(1));

    rand_csr(); run_op(3'd0, 5'd0, 4, 0);
    chk("stop4_cycle", 128'(g_rsp_cyc), 128'(7));
    chk("stop4_pulses", 128'(g_strobes), 128'(1));

    rand_csr(); run_op(3'd2, 5'd0, 0, 2);
    chk("flash_wait_rsps", 128'(g_rsp_cnt), 128'(0));
    rand_csr(); run_op(3'd4, 5'd3, 1, 1);
    chk("flash_issue_pulses", 128'(g_strobes), 128'(0));
    rand_csr(); run_op(3'd3, 5'd0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      rand_csr();
      k = int'($urandom_range(0, 2));
      f = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, k + 2)) : 0;
      run_op(3'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? 5'($urandom()) : 5'($urandom_range(0, 8)), k, f);
    end

    // Reset during ISSUE must abort silently and restart the FILL counter.
    rand_csr();
    @(negedge Clk);
    OpValid = 1'b1; OpCode = 3'd2;
    @(negedge Clk);
    OpValid = 1'b0; Rest = 1'b1;
    s = 0; r = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      s += int'(CsrSerchTlbAble) + int'(CsrWriteTlbAble) + int'(CsrInvEn);
      r += int'(RspValid);
      if (c == 0) begin
        chk("midrst_waddr", 128'(CsrWriteTlbAddr), 128'(0));
        chk("midrst_rspidx", 128'(RspTlbIdx), 128'(0));
        chk("midrst_raddr", 128'(CsrReadTlbAddr), 128'(0));
      end
      if (c == 2) Rest = 1'b0;
    end
    chk("midrst_pulses", 128'(s), 128'(0));
    chk("midrst_rsps", 128'(r), 128'(0));
    chk("midrst_ready", 128'(OpReady), 128'(1));
    rand_csr(); run_op(3'd3, 5'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL: Clk  in  1  sole clock; all state changes on posedge Clk.
REQ-002 SHALL: Rest  in  1  asynchronous, active-high reset.
REQ-003 SHALL: OpValid in 1 / OpReady out 1  request handshake; accepted when both high at posedge.
REQ-004 SHALL: OpCode in 3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV, 5-7 illegal.
REQ-005 SHALL: OpInvOp in 5, OpInvAsid in 10, OpInvVppn in 19  INVTLB operands, used only when OpCode=4.
REQ-006 SHALL: CsrTlbIdx, CsrTlbEhi, CsrTlbElo0, CsrTlbElo1 in 32 each; CsrAsid in 10  current CSR values.
REQ-007 SHALL: CsrSerchTlbAble out 1; CsrSerchInfrom out 64; CsrSerchIdxDate in 6; MmuSerchHit in 1  MMU search port.
REQ-008 SHALL: CsrReadTlbAddr out 6; CsrReadTlbDate in 89  MMU read port, packing {Vppn19,Asid10,G,Ps6,E,V0,D0,Mat0[2],Plv0[2],Ppn0[20],V1,D1,Mat1[2],Plv1[2],Ppn1[20]} MSB first.
REQ-009 SHALL: CsrWriteTlbAble out 1; CsrWriteTlbAddr out 6; CsrWriteTlbDate out 89 (same packing as REQ-008).
REQ-010 SHALL: CsrInvEn out 1; CsrInvOp out 5; CsrInvAsid out 10; CsrInvVppn out 19.
REQ-011 SHALL: MmuStop in 1 (hold issue), MmuFlash in 1 (abort).
REQ-012 SHALL: RspValid out 1; RspErr out 1; RspWeMask out 4 {Idx,Ehi,Elo,Asid}; RspTlbIdx, RspTlbEhi, RspTlbElo0, RspTlbElo1 out 32; RspAsid out 10.

Function
REQ-013 SHALL: FSM states IDLE, ISSUE, WAIT, RESP; OpReady=1 only in IDLE.
REQ-014 SHALL: on acceptance, latch OpCode and all operands; IDLE->ISSUE.
REQ-015 SHALL: in ISSUE, drive exactly one port strobe for one cycle (SRCH: CsrSerchTlbAble; WR/FILL: CsrWriteTlbAble; INV: CsrInvEn; RD: address only), then ->WAIT; if MmuStop=1, strobes stay low and state stays ISSUE.
REQ-016 SHALL: WAIT samples CsrSerchIdxDate/MmuSerchHit/CsrReadTlbDate into registers, ->RESP; RESP pulses RspValid for one cycle, ->IDLE; RspValid is therefore high in the 3rd cycle after acceptance when MmuStop=0.
REQ-017 SHALL: CsrSerchInfrom = {CsrTlbEhi[31:13], CsrAsid, 35'b0}.
REQ-018 SHALL: CSR field map: TLBIDX Index[5:0], PS[29:24], NE[31]; EHI VPPN[31:13]; ELO V[0], D[1], PLV[3:2], MAT[5:4], G[6], PPN[27:8].
REQ-019 SHALL: SRCH hit -> RspTlbIdx = CsrTlbIdx with Index=SerchIdx, NE=0; miss -> NE=1, other bits kept; RspWeMask=1000.
REQ-020 SHALL: RD, addr=CsrTlbIdx[5:0]; E=1 -> EHI/ELO0/ELO1/ASID/PS from entry, NE=0, mask=1111; E=0 -> NE=1, PS=0, EHI/ELO0/ELO1/ASID=0, mask=1111.
REQ-021 SHALL: WR writes addr CsrTlbIdx[5:0]; FILL writes addr = value of a free-running 6-bit counter (increments every cycle, wraps 63->0) sampled at acceptance; data E=~CsrTlbIdx[31], G=Elo0.G & Elo1.G, Asid=CsrAsid, Ps=TLBIDX.PS, rest from EHI/ELO; mask=0000.
REQ-022 SHALL: INV with OpInvOp<=6 pulses CsrInvEn with latched operands; OpInvOp>6 or OpCode 5-7 -> no strobe, RspErr=1 with RspValid, mask=0000.
REQ-023 SHALL: MmuFlash=1 in any state forces IDLE next cycle, suppresses RspValid and any strobe not yet issued; MmuFlash in ISSUE has priority over the strobe.
REQ-024 SHALL: outputs other than RspValid hold their last values outside RESP; strobes are registered (no combinational path from OpValid).

Reset
REQ-025 SHALL: while Rest=1: state IDLE, OpReady=1 after release, all strobes 0, RspValid/RspErr 0, all Rsp* and Csr* address/data outputs 0, FILL counter 0; Rest mid-operation aborts with no strobe or response.

Verification
REQ-026 SHALL: SRCH, CsrTlbEhi=0x12346000, MmuSerchHit=1, idx=5 -> CsrSerchInfrom[63:45]=0x091A3, RspTlbIdx[31]=0, [5:0]=5, RspValid at cycle 3.
REQ-027 SHALL: RD entry 7 with E=0 -> RspTlbIdx[31]=1, PS=0, RspTlbEhi=0, RspWeMask=1111.
REQ-028 SHALL: WR, CsrTlbIdx=0x0C00000A -> CsrWriteTlbAddr=10, Ps=12, E=1, single-cycle CsrWriteTlbAble.
REQ-029 SHALL: INV OpInvOp=7 -> CsrInvEn never high, RspErr=1, RspValid once.
REQ-030 SHALL: MmuStop held 4 cycles in ISSUE then released -> one strobe, RspValid 7 cycles after acceptance; MmuFlash in WAIT -> no RspValid, OpReady=1 next cycle.
